button_go_ctrl: RTL

BUTTON_GO_CTRL -- requirements
Module: button_go_ctrl

---
 rtl/button_go_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/button_go_ctrl.sv
// Push-button front end: synchroniser, press/release debounce and a one-shot go pulse to a downstream counter FSM.
// Optional: define BUTTON_GO_CTRL_TIMEOUT_EN to add a WAIT_DONE watchdog that drives a one-cycle timeout pulse.
module button_go_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       done,
  output logic       go,
  output logic       busy,
  output logic [7:0] press_count,
  output logic       timeout
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    FIRE,
    WAIT_DONE,
    WAIT_RELEASE
  } state_t;

  generate
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("button_go_ctrl: SYNC_STAGES must be >= 2, DEBOUNCE_CYCLES and TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // btn is asynchronous; only the last stage of this chain is ever looked at.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

`ifdef BUTTON_GO_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic            wd_hit;
  logic            expire;
  logic            timeout_q;

  assign wd_hit = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Counts only while in WAIT_DONE, so it is already zero when the state is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      if (state_q != WAIT_DONE) begin
        wd_q <= '0;
      end else if (!wd_hit) begin
        wd_q <= wd_q + WD_W'(1);
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef BUTTON_GO_CTRL_TIMEOUT_EN
    expire  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = DEBOUNCE;
          cnt_d   = '0;
        end
      end
      DEBOUNCE: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = FIRE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIRE: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // done wins over a simultaneous watchdog expiry.
        if (done) begin
          state_d = WAIT_RELEASE;
          cnt_d   = '0;
        end
`ifdef BUTTON_GO_CTRL_TIMEOUT_EN
        else if (wd_hit) begin
          state_d = WAIT_RELEASE;
          cnt_d   = '0;
          expire  = 1'b1;
        end
`endif
      end
      WAIT_RELEASE: begin
        // A new press is only armed after a fully debounced release.
        if (btn_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_count <= 8'd0;
    end else if (state_q == FIRE) begin
      press_count <= press_count + 8'd1;
    end
  end

  assign go   = (state_q == FIRE);
  assign busy = (state_q == FIRE) || (state_q == WAIT_DONE);

endmodule
